// File: rtl/reset_boot_sequencer.sv
// rtl/reset_boot_sequencer.sv - holds the system reset for CYCLES clocks after any reset cause
module reset_boot_sequencer #(
    parameter int CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soft_rst_i,
    output logic        rst_n_o,
    output logic        rst_o,
    output logic        busy_o,
    output logic        boot_done_o,
    output logic [15:0] count_o
);

    if (CYCLES < 1 || CYCLES > 65535) begin : g_bad_cycles
        $error("reset_boot_sequencer: CYCLES must be in 1..65535");
    end

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CYCLES - 1);

    // Declaration initialisers give the power-up boot hold without an rst pulse.
    state_t      r_state     = HOLD;
    logic [15:0] r_count     = 16'd0;
    logic        r_boot_done = 1'b0;

    state_t      w_state_nxt;
    logic [15:0] w_count_nxt;
    logic        w_boot_done_nxt;

    always_ff @(posedge clk) begin
        r_state     <= w_state_nxt;
        r_count     <= w_count_nxt;
        r_boot_done <= w_boot_done_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_boot_done_nxt = 1'b0;
        if (rst) begin
            w_state_nxt = HOLD;
            w_count_nxt = 16'd0;
        end else begin
            case (r_state)
                HOLD: begin
                    // Counter saturates at the last value so it never wraps.
                    if (r_count == LP_LAST) begin
                        w_state_nxt     = RUN;
                        w_boot_done_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 16'd1;
                    end
                end
                RUN: begin
                    if (soft_rst_i) begin
                        w_state_nxt = HOLD;
                        w_count_nxt = 16'd0;
                    end
                end
                default: begin
                    w_state_nxt = HOLD;
                    w_count_nxt = 16'd0;
                end
            endcase
        end
    end

    assign rst_n_o     = (r_state == RUN);
    assign rst_o       = (r_state != RUN);
    assign busy_o      = (r_state == HOLD);
    assign boot_done_o = r_boot_done;
    assign count_o     = r_count;

endmodule

// File: tb/tb_reset_boot_sequencer.sv
// tb/tb_reset_boot_sequencer.sv - scoreboard bench for reset_boot_sequencer (CYCLES=20 and CYCLES=1)
module tb_reset_boot_sequencer;

    localparam int C_A = 20;
    localparam int C_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic soft_rst = 1'b0;

    logic        a_rst_n, a_rst, a_busy, a_done;
    logic [15:0] a_count;
    logic        b_rst_n, b_rst, b_busy, b_done;
    logic [15:0] b_count;

    reset_boot_sequencer #(.CYCLES(C_A)) u_dut_a (
        .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
        .rst_n_o(a_rst_n), .rst_o(a_rst), .busy_o(a_busy),
        .boot_done_o(a_done), .count_o(a_count)
    );

    reset_boot_sequencer #(.CYCLES(C_B)) u_dut_b (
        .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
        .rst_n_o(b_rst_n), .rst_o(b_rst), .busy_o(b_busy),
        .boot_done_o(b_done), .count_o(b_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run_a;
        logic        done_a;
        int          count_a;
        logic        run_b;
        logic        done_b;
        int          count_b;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: edges elapsed since the last restart; released once it reaches C.
    int el_a = 0;
    int el_b = 0;

    function automatic int advance(input int el, input int c, input logic r, input logic s);
        if (r) return 0;
        if (el >= c && s) return 0;
        return (el + 1 > c + 1) ? c + 1 : el + 1;
    endfunction

    function automatic exp_t predict(input int ea, input int eb, input int cy);
        exp_t e;
        e.run_a   = (ea >= C_A);
        e.done_a  = (ea == C_A);
        e.count_a = (ea < C_A) ? ea : C_A - 1;
        e.run_b   = (eb >= C_B);
        e.done_b  = (eb == C_B);
        e.count_b = (eb < C_B) ? eb : C_B - 1;
        e.cycle   = cy;
        return e;
    endfunction

    task automatic cmp(input string name, input int act, input int req, input int cy);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0d required %0d", name, cy, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp("a_rst_n",  int'(a_rst_n), int'(e.run_a), e.cycle);
        cmp("a_rst_o",  int'(a_rst),   int'(!e.run_a), e.cycle);
        cmp("a_busy",   int'(a_busy),  int'(!e.run_a), e.cycle);
        cmp("a_done",   int'(a_done),  int'(e.done_a), e.cycle);
        cmp("a_count",  int'(a_count), e.count_a, e.cycle);
        cmp("b_rst_n",  int'(b_rst_n), int'(e.run_b), e.cycle);
        cmp("b_rst_o",  int'(b_rst),   int'(!e.run_b), e.cycle);
        cmp("b_busy",   int'(b_busy),  int'(!e.run_b), e.cycle);
        cmp("b_done",   int'(b_done),  int'(e.done_b), e.cycle);
        cmp("b_count",  int'(b_count), e.count_b, e.cycle);
    endtask

    task automatic step(input logic r, input logic s);
        rst      = r;
        soft_rst = s;
        @(posedge clk);
        #1;
        cyc++;
        el_a = advance(el_a, C_A, r, s);
        el_b = advance(el_b, C_B, r, s);
        exp_q.push_back(predict(el_a, el_b, cyc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check_all(exp_q.pop_front());
        end
    end

    initial begin
        #1;
        check_all(predict(0, 0, 0));

        idle(25);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        idle(25);
        step(1'b1, 1'b0);
        idle(10);
        step(1'b1, 1'b0);
        idle(25);
        step(1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b1);
        idle(25);
        step(1'b1, 1'b1);
        idle(25);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
        end

        idle(2);
        @(negedge clk);
        #1;
        cmp("queue_drained", exp_q.size(), 0, cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
